// File: rtl/fproc_arb_pkg.sv
// Shared types and helpers for the fproc round-robin arbiter.
package fproc_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } arb_state_e;

    // Index width for a pointer over n entries, never narrower than one bit.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fproc_arbiter_rr_pick.sv
// Combinational round-robin select: the first set request at or above ptr_i, wrapping.
module rr_pick
    import fproc_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = ptr_width(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [PW-1:0] gnt_idx_o,
    output logic          gnt_valid_o
);

    int idx;

    always_comb begin
        gnt_idx_o   = '0;
        gnt_valid_o = 1'b0;
        idx         = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr_i) + k) % N;
            if (!gnt_valid_o && req_i[idx]) begin
                gnt_valid_o = 1'b1;
                gnt_idx_o   = PW'(idx);
            end
        end
    end

endmodule

// File: rtl/fproc_arbiter.sv
// Shares one fproc backend between N_CORES cores, granting captured requests round-robin.
// Optional WAIT watchdog enabled by defining FPROC_ARB_TIMEOUT_EN.
module fproc_arbiter
    import fproc_arb_pkg::*;
#(
    parameter int N_CORES            = 4,
    parameter int FPROC_ID_WIDTH     = 8,
    parameter int FPROC_RESULT_WIDTH = 32,
    parameter int TIMEOUT_CYCLES     = 1024,
    parameter logic [FPROC_RESULT_WIDTH-1:0] TIMEOUT_DATA = '1
) (
    input  logic                                  clk_i,
    input  logic                                  reset_i,
    input  logic [N_CORES-1:0]                    core_en_i,
    input  logic [N_CORES*FPROC_ID_WIDTH-1:0]     core_id_i,
    output logic [N_CORES-1:0]                    core_ready_o,
    output logic [N_CORES*FPROC_RESULT_WIDTH-1:0] core_data_o,
    output logic                                  fp_enable_o,
    output logic [FPROC_ID_WIDTH-1:0]             fp_id_o,
    input  logic                                  fp_ready_i,
    input  logic [FPROC_RESULT_WIDTH-1:0]         fp_data_i,
    output logic                                  busy_o,
    output logic                                  timeout_err_o
);

    localparam int PW = ptr_width(N_CORES);
    localparam int IW = FPROC_ID_WIDTH;
    localparam int RW = FPROC_RESULT_WIDTH;

    arb_state_e                 state_q, state_d;
    logic [N_CORES-1:0]         pending_q, pending_d;
    logic [N_CORES*IW-1:0]      id_q, id_d;
    logic [PW-1:0]              grant_q, grant_d;
    logic [PW-1:0]              rr_ptr_q, rr_ptr_d;
    logic                       fp_enable_q, fp_enable_d;
    logic [IW-1:0]              fp_id_q, fp_id_d;
    logic [N_CORES-1:0]         core_ready_q, core_ready_d;
    logic [N_CORES*RW-1:0]      core_data_q, core_data_d;
    logic                       timeout_err_q, timeout_err_d;

    logic [N_CORES-1:0]         req;
    logic [PW-1:0]              gnt_idx;
    logic                       gnt_valid;
    logic                       wait_phase;
    logic                       tmo_hit;
    logic                       resp_fire;
    logic [RW-1:0]              resp_data;

    assign req = pending_q | core_en_i;

    rr_pick #(
        .N  (N_CORES),
        .PW (PW)
    ) u_rr_pick (
        .req_i       (req),
        .ptr_i       (rr_ptr_q),
        .gnt_idx_o   (gnt_idx),
        .gnt_valid_o (gnt_valid)
    );

    // The fp_enable cycle itself never accepts a response.
    assign wait_phase = (state_q == WAIT) && !fp_enable_q;

`ifdef FPROC_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;

    assign tmo_hit = wait_phase && (tmo_cnt_q == '0);

    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (state_q == IDLE && gnt_valid) begin
            tmo_cnt_d = CW'(TIMEOUT_CYCLES - 1);
        end else if (wait_phase && tmo_cnt_q != '0) begin
            tmo_cnt_d = tmo_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    assign resp_fire = wait_phase && (fp_ready_i || tmo_hit);
    assign resp_data = fp_ready_i ? fp_data_i : TIMEOUT_DATA;

    always_comb begin
        state_d       = state_q;
        pending_d     = pending_q;
        id_d          = id_q;
        grant_d       = grant_q;
        rr_ptr_d      = rr_ptr_q;
        fp_enable_d   = 1'b0;
        fp_id_d       = fp_id_q;
        core_ready_d  = '0;
        core_data_d   = core_data_q;
        timeout_err_d = timeout_err_q;

        // A pulse while already pending keeps the originally captured id.
        for (int i = 0; i < N_CORES; i++) begin
            if (core_en_i[i] && !pending_q[i]) begin
                pending_d[i]      = 1'b1;
                id_d[i*IW +: IW]  = core_id_i[i*IW +: IW];
            end
        end

        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    fp_enable_d = 1'b1;
                    grant_d     = gnt_idx;
                    fp_id_d     = pending_q[gnt_idx] ? id_q[int'(gnt_idx)*IW +: IW]
                                                     : core_id_i[int'(gnt_idx)*IW +: IW];
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                if (resp_fire) begin
                    core_ready_d[grant_q]               = 1'b1;
                    core_data_d[int'(grant_q)*RW +: RW] = resp_data;
                    pending_d[grant_q]                  = 1'b0;
                    rr_ptr_d = (int'(grant_q) == N_CORES - 1) ? '0 : grant_q + 1'b1;
                    state_d  = IDLE;
`ifdef FPROC_ARB_TIMEOUT_EN
                    if (!fp_ready_i) begin
                        timeout_err_d = 1'b1;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= IDLE;
            pending_q     <= '0;
            id_q          <= '0;
            grant_q       <= '0;
            rr_ptr_q      <= '0;
            fp_enable_q   <= 1'b0;
            fp_id_q       <= '0;
            core_ready_q  <= '0;
            core_data_q   <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            id_q          <= id_d;
            grant_q       <= grant_d;
            rr_ptr_q      <= rr_ptr_d;
            fp_enable_q   <= fp_enable_d;
            fp_id_q       <= fp_id_d;
            core_ready_q  <= core_ready_d;
            core_data_q   <= core_data_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign core_ready_o  = core_ready_q;
    assign core_data_o   = core_data_q;
    assign fp_enable_o   = fp_enable_q;
    assign fp_id_o       = fp_id_q;
    assign busy_o        = (state_q == WAIT);
    assign timeout_err_o = timeout_err_q;

endmodule
